hs_rx_bridge: RTL

Multi-channel receive bridge that terminates CHANNELS asynchronous four-phase (req/ack, bundled-data) producers in the clk domain. It synchronises each request, arbitrates round-robin among pending channels, and captures one word per cycle into a shared FIFO. The FIFO presents a valid/ready stream tagged with the source channel. It is the clocked, parametrised successor of the single-channel C-element handshake controller and sits at the asynchronous-to-synchronous boundary of the bridge.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/hs_rx_bridge_chan.sv | 67 ++++++
 rtl/hs_rx_bridge.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the four-phase receive bridge: defaults, channel
// state encoding and a constant-friendly ceil(log2) helper.
package bridge_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } chan_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_rx_bridge_chan.sv
// One four-phase producer termination: two-flop request synchroniser and the
// IDLE/ACK handshake state machine whose state bit is the acknowledge.
module hs_chan
    import bridge_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic req_i,
    input  logic grant_i,
    input  logic full_i,
    output logic ack_o,
    output logic elig_o,
    output logic push_o
);

    logic        sync1_q;
    logic        req_s_q;
    chan_state_e state_q;
    chan_state_e state_d;

    // Two-flop synchroniser for the asynchronous request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            req_s_q <= 1'b0;
        end else begin
            sync1_q <= req_i;
            req_s_q <= sync1_q;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign elig_o = req_s_q & (state_q == ST_IDLE);
    assign push_o = elig_o & grant_i & ~full_i;
    assign ack_o  = (state_q == ST_ACK);

    // Next-state: capture on push, return to IDLE once the request drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push_o) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!req_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/hs_rx_bridge.sv
// Multi-channel four-phase receive bridge: per-channel handshake terminators,
// round-robin arbitration and a shared channel-tagged FIFO with valid/ready output.
module hs_rx_bridge
    import bridge_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    localparam int ID_W     = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1,
    localparam int LVL_W    = clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [CHANNELS-1:0]        req_i,
    input  logic [CHANNELS*DATA_W-1:0] data_i,
    output logic [CHANNELS-1:0]        ack_o,
    output logic [CHANNELS-1:0]        pend_o,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ID_W-1:0]            out_chan,
    output logic [LVL_W-1:0]           level_o
);

    localparam int PTR_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;

    logic [CHANNELS-1:0] elig;
    logic [CHANNELS-1:0] gnt;
    logic [CHANNELS-1:0] push_vec;
    logic [DATA_W-1:0]   chan_data [CHANNELS];
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W-1:0]     scan_idx;
    logic [ID_W:0]       scan_sum;
    logic                scan_hit;
    logic                gnt_found;
    logic                full, push, pop;
    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [ID_W-1:0]     mem_chan_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;

    assign full = (level_q == LVL_W'(DEPTH));
    assign pop  = out_valid & out_ready;
    assign push = |push_vec;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign chan_data[c] = data_i[c*DATA_W +: DATA_W];
        hs_chan u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .req_i   (req_i[c]),
            .grant_i (gnt[c]),
            .full_i  (full),
            .ack_o   (ack_o[c]),
            .elig_o  (elig[c]),
            .push_o  (push_vec[c])
        );
    end

    // Round-robin scan from rr_ptr; nothing is granted while the FIFO is full.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        scan_hit  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_sum      = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            scan_idx      = (scan_sum >= (ID_W+1)'(CHANNELS)) ?
                            ID_W'(scan_sum - (ID_W+1)'(CHANNELS)) : ID_W'(scan_sum);
            scan_hit      = elig[scan_idx] & ~gnt_found & ~full;
            gnt[scan_idx] = gnt[scan_idx] | scan_hit;
            gnt_idx       = scan_hit ? scan_idx : gnt_idx;
            gnt_found     = gnt_found | scan_hit;
        end
    end

    assign pend_o = elig & ~gnt;

    // Pointer and occupancy next-state.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (gnt_found) begin
            rr_ptr_d = (gnt_idx == ID_W'(CHANNELS - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Arbiter pointer, FIFO pointers/occupancy and storage. Storage is cleared
    // so the head outputs read zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_data_q[e] <= '0;
                mem_chan_q[e] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (push) begin
                mem_data_q[wr_ptr_q] <= chan_data[gnt_idx];
                mem_chan_q[wr_ptr_q] <= gnt_idx;
            end
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_chan  = mem_chan_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule
